// File: rtl/reg_file_sb.sv
// Decode-stage register file: two registered read ports with optional write
// bypass, one write port, per-register pending scoreboard and a debug read port.
module reg_file_sb #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] rs,
  input  logic [ADDR_WIDTH-1:0] rt,
  output logic [DATA_WIDTH-1:0] A,
  output logic [DATA_WIDTH-1:0] B,
  input  logic [ADDR_WIDTH-1:0] write_reg,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  reg_write,
  input  logic                  issue_valid,
  input  logic [ADDR_WIDTH-1:0] issue_reg,
  output logic                  rs_pending,
  output logic                  rt_pending,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  output logic [DATA_WIDTH-1:0] dbg_data
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0]      pending;
  logic [DEPTH-1:0]      pending_next;
  logic [DATA_WIDTH-1:0] a_next;
  logic [DATA_WIDTH-1:0] b_next;
  logic                  wr_eff;
  logic                  issue_eff;

  // True when idx is the hardwired zero register.
  function automatic logic is_zero(input logic [ADDR_WIDTH-1:0] idx);
    return (ZERO_REG != 0) && (idx == '0);
  endfunction

  assign wr_eff    = reg_write && !is_zero(write_reg);
  assign issue_eff = issue_valid && !is_zero(issue_reg);

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    a_next = regs[rs];
    b_next = regs[rt];
    if ((BYPASS != 0) && wr_eff && (write_reg == rs)) a_next = write_data;
    if ((BYPASS != 0) && wr_eff && (write_reg == rt)) b_next = write_data;
    if (is_zero(rs)) a_next = '0;
    if (is_zero(rt)) b_next = '0;
  end

  // Clear before set: a producer issued this cycle supersedes the one completing.
  always_comb begin
    pending_next = pending;
    if (wr_eff)    pending_next[write_reg] = 1'b0;
    if (issue_eff) pending_next[issue_reg] = 1'b1;
  end

  // NOTE: the storage array is reset because a cleared file is part of the
  // architectural contract, not just a simulation nicety.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      pending <= '0;
      A       <= '0;
      B       <= '0;
    end else begin
      if (wr_eff) regs[write_reg] <= write_data;
      pending <= pending_next;
      A       <= a_next;
      B       <= b_next;
    end
  end

  // A writeback this cycle resolves the hazard without waiting for the edge.
  assign rs_pending = pending[rs] && !(wr_eff && (write_reg == rs));
  assign rt_pending = pending[rt] && !(wr_eff && (write_reg == rt));

  assign dbg_data = is_zero(dbg_addr) ? '0 : regs[dbg_addr];

endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench for reg_file_sb: default instance (32b, zero reg, bypass)
// and an alternate instance (64b, 8 entries, no zero reg, no bypass).
module tb_reg_file_sb;

  logic        clk;
  logic        rst;

  logic [4:0]  rs, rt, write_reg, issue_reg, dbg_addr;
  logic [31:0] write_data;
  logic        reg_write, issue_valid;
  logic [31:0] A, B, dbg_data;
  logic        rs_pending, rt_pending;

  logic [2:0]  x_rs, x_rt, x_wr, x_ir, x_dbg;
  logic [63:0] x_wd;
  logic        x_we, x_iv;
  logic [63:0] x_A, x_B, x_dbg_data;
  logic        x_rs_pending, x_rt_pending;

  int tests = 0;
  int fails = 0;

  // Reference state: register contents and pending flags per instance.
  logic [31:0] m_reg [32];
  logic        m_pend [32];
  logic [63:0] n_reg [8];
  logic        n_pend [8];

  reg_file_sb u_dut (
    .clk(clk), .rst(rst), .rs(rs), .rt(rt), .A(A), .B(B),
    .write_reg(write_reg), .write_data(write_data), .reg_write(reg_write),
    .issue_valid(issue_valid), .issue_reg(issue_reg),
    .rs_pending(rs_pending), .rt_pending(rt_pending),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  reg_file_sb #(.DATA_WIDTH(64), .ADDR_WIDTH(3), .ZERO_REG(0), .BYPASS(0)) u_alt (
    .clk(clk), .rst(rst), .rs(x_rs), .rt(x_rt), .A(x_A), .B(x_B),
    .write_reg(x_wr), .write_data(x_wd), .reg_write(x_we),
    .issue_valid(x_iv), .issue_reg(x_ir),
    .rs_pending(x_rs_pending), .rt_pending(x_rt_pending),
    .dbg_addr(x_dbg), .dbg_data(x_dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_models();
    for (int i = 0; i < 32; i++) begin m_reg[i] = '0; m_pend[i] = 1'b0; end
    for (int i = 0; i < 8; i++)  begin n_reg[i] = '0; n_pend[i] = 1'b0; end
  endtask

  task automatic idle_all();
    reg_write = 1'b0; issue_valid = 1'b0; x_we = 1'b0; x_iv = 1'b0;
  endtask

  function automatic logic [63:0] alt_val(input int i);
    return 64'h0123_4567_89AB_CDEF ^ (64'(7 - i) << 56);
  endfunction

  // One clock: check combinational outputs against the model, predict A/B,
  // advance the model, cross the edge and check the registered outputs.
  task automatic tick();
    logic        eff;
    logic [31:0] ea, eb;
    logic [63:0] xa, xb;
    #1;
    eff = reg_write && (write_reg != 5'd0);
    check("rs_pending", 64'(rs_pending), 64'(m_pend[rs] && !(eff && write_reg == rs)));
    check("rt_pending", 64'(rt_pending), 64'(m_pend[rt] && !(eff && write_reg == rt)));
    check("dbg_data", 64'(dbg_data), 64'((dbg_addr == 5'd0) ? 32'd0 : m_reg[dbg_addr]));
    ea = (rs == 5'd0) ? 32'd0 : (eff && write_reg == rs) ? write_data : m_reg[rs];
    eb = (rt == 5'd0) ? 32'd0 : (eff && write_reg == rt) ? write_data : m_reg[rt];
    check("x_rs_pending", 64'(x_rs_pending), 64'(n_pend[x_rs] && !(x_we && x_wr == x_rs)));
    check("x_rt_pending", 64'(x_rt_pending), 64'(n_pend[x_rt] && !(x_we && x_wr == x_rt)));
    check("x_dbg_data", x_dbg_data, n_reg[x_dbg]);
    xa = n_reg[x_rs];
    xb = n_reg[x_rt];
    if (eff) begin m_reg[write_reg] = write_data; m_pend[write_reg] = 1'b0; end
    if (issue_valid && issue_reg != 5'd0) m_pend[issue_reg] = 1'b1;
    if (x_we) begin n_reg[x_wr] = x_wd; n_pend[x_wr] = 1'b0; end
    if (x_iv) n_pend[x_ir] = 1'b1;
    @(posedge clk);
    #1;
    check("A", 64'(A), 64'(ea));
    check("B", 64'(B), 64'(eb));
    check("x_A", x_A, xa);
    check("x_B", x_B, xb);
  endtask

  // Called with rst already high: everything must read clean at once, and
  // writes/issues presented across edges during reset must be ignored.
  task automatic reset_check();
    #1;
    check("rst_A", 64'(A), 64'd0);
    check("rst_B", 64'(B), 64'd0);
    check("rst_dbg", 64'(dbg_data), 64'd0);
    check("rst_x_A", x_A, 64'd0);
    check("rst_x_dbg", x_dbg_data, 64'd0);
    clear_models();
    write_reg = 5'd6; write_data = 32'h6666_6666; reg_write = 1'b1;
    issue_valid = 1'b1; issue_reg = 5'd6;
    x_wr = 3'd6; x_wd = '1; x_we = 1'b1; x_iv = 1'b1; x_ir = 3'd6;
    for (int i = 0; i < 32; i++) begin
      rs = 5'(i); rt = 5'(31 - i); x_rs = 3'(i); x_rt = 3'(i);
      #1;
      check("rst_rs_pending", 64'(rs_pending), 64'd0);
      check("rst_rt_pending", 64'(rt_pending), 64'd0);
      check("rst_x_rs_pending", 64'(x_rs_pending), 64'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    idle_all();
    dbg_addr = 5'd6; rs = 5'd6; x_dbg = 3'd6; x_rs = 3'd6;
    tick();
  endtask

  initial begin
    rst = 1'b1;
    rs = '0; rt = '0; write_reg = '0; issue_reg = '0; dbg_addr = '0;
    write_data = '0; reg_write = 1'b0; issue_valid = 1'b0;
    x_rs = '0; x_rt = '0; x_wr = '0; x_ir = '0; x_dbg = '0;
    x_wd = '0; x_we = 1'b0; x_iv = 1'b0;
    clear_models();
    #1;
    reset_check();

    // Reset clear mid-operation.
    write_reg = 5'd5; write_data = 32'hDEAD_BEEF; reg_write = 1'b1;
    x_wr = 3'd5; x_wd = 64'hFEED_FACE_DEAD_BEEF; x_we = 1'b1;
    tick();
    idle_all();
    rs = 5'd5; rt = 5'd5; dbg_addr = 5'd5; x_rs = 3'd5;
    tick();
    check("pre_rst_A", 64'(A), 64'hDEAD_BEEF);
    #2;
    rst = 1'b1;
    reset_check();

    // Write then read: dbg sees it after the write edge, A one read later.
    write_reg = 5'd7; write_data = 32'h1234_5678; reg_write = 1'b1;
    dbg_addr = 5'd7; rs = 5'd0; rt = 5'd0;
    tick();
    check("lat_dbg", 64'(dbg_data), 64'h1234_5678);
    idle_all();
    rs = 5'd7;
    tick();
    check("lat_A", 64'(A), 64'h1234_5678);

    // Same-cycle write and read: bypass on main, old value on alt.
    write_reg = 5'd3; write_data = 32'hA5A5_A5A5; reg_write = 1'b1; rs = 5'd3; rt = 5'd3;
    x_wr = 3'd3; x_wd = 64'hA5A5_A5A5_A5A5_A5A5; x_we = 1'b1; x_rs = 3'd3; x_rt = 3'd3;
    tick();
    check("byp_A", 64'(A), 64'hA5A5_A5A5);
    check("byp_B", 64'(B), 64'hA5A5_A5A5);
    check("nobyp_A", x_A, 64'd0);
    check("nobyp_B", x_B, 64'd0);
    idle_all();
    tick();
    check("nobyp_next_A", x_A, 64'hA5A5_A5A5_A5A5_A5A5);

    // Zero register: writes and issues to index 0 are ignored on main only.
    write_reg = 5'd0; write_data = '1; reg_write = 1'b1;
    issue_valid = 1'b1; issue_reg = 5'd0; rs = 5'd0; dbg_addr = 5'd0;
    x_wr = 3'd0; x_wd = '1; x_we = 1'b1; x_rs = 3'd0;
    tick();
    idle_all();
    tick();
    check("zero_A", 64'(A), 64'd0);
    check("zero_dbg", 64'(dbg_data), 64'd0);
    check("zero_pending", 64'(rs_pending), 64'd0);
    check("nozero_A", x_A, 64'hFFFF_FFFF_FFFF_FFFF);

    // Scoreboard: issue, combinational clear on writeback, set wins on collision.
    issue_valid = 1'b1; issue_reg = 5'd9; rs = 5'd9; rt = 5'd9;
    tick();
    idle_all();
    #1;
    check("sb_set", 64'(rs_pending), 64'd1);
    write_reg = 5'd9; write_data = 32'hCAFE_F00D; reg_write = 1'b1;
    #1;
    check("sb_wb_clear", 64'(rs_pending), 64'd0);
    tick();
    check("sb_wb_A", 64'(A), 64'hCAFE_F00D);
    issue_valid = 1'b1; issue_reg = 5'd9; write_data = 32'h0BAD_CAFE;
    tick();
    idle_all();
    #1;
    check("sb_set_wins", 64'(rs_pending), 64'd1);
    tick();

    // Alternate instance: every 64-bit entry independently writable.
    for (int i = 0; i < 8; i++) begin
      x_wr = 3'(i); x_wd = alt_val(i); x_we = 1'b1;
      tick();
    end
    idle_all();
    for (int i = 0; i < 8; i++) begin
      x_rs = 3'(i); x_rt = 3'(7 - i); x_dbg = 3'(i);
      tick();
      check("alt_read", x_A, alt_val(i));
    end
    check("alt_r7", x_dbg_data, 64'h0123_4567_89AB_CDEF);

    // Random traffic on both instances against the model.
    for (int n = 0; n < 400; n++) begin
      rs = 5'($urandom_range(0, 11)); rt = 5'($urandom_range(0, 11));
      write_reg = 5'($urandom_range(0, 11)); issue_reg = 5'($urandom_range(0, 11));
      dbg_addr = 5'($urandom_range(0, 31));
      write_data = $urandom();
      reg_write = 1'($urandom_range(0, 1)); issue_valid = 1'($urandom_range(0, 1));
      x_rs = 3'($urandom()); x_rt = 3'($urandom()); x_wr = 3'($urandom());
      x_ir = 3'($urandom()); x_dbg = 3'($urandom());
      x_wd = {$urandom(), $urandom()};
      x_we = 1'($urandom_range(0, 1)); x_iv = 1'($urandom_range(0, 1));
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Parametrised general-purpose register file for the decode stage: two read ports, one write port, and a per-register pending scoreboard.
- Reads are registered into A/B, with optional write-to-read bypass. Register 0 is optionally hardwired to zero.
- The scoreboard marks a destination busy at issue and clears it at writeback, so the decode stage can raise stalls for operands whose producer has not written back.
- A combinational debug read port replaces ad-hoc simulation dumps.

Parameters:
- DATA_WIDTH, 32, width of each register and of all data ports.
- ADDR_WIDTH, 5, register index width; depth = 2**ADDR_WIDTH.
- ZERO_REG, 1, 1 = index 0 always reads 0 and ignores writes and issues; 0 = index 0 is an ordinary register.
- BYPASS, 1, 1 = a same-cycle write to the read index is forwarded into A/B; 0 = A/B show the pre-write value.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- rs  in  ADDR_WIDTH  read index, port A.
- rt  in  ADDR_WIDTH  read index, port B.
- A  out  DATA_WIDTH  registered read data for rs.
- B  out  DATA_WIDTH  registered read data for rt.
- write_reg  in  ADDR_WIDTH  write index.
- write_data  in  DATA_WIDTH  write data.
- reg_write  in  1  write enable; also clears pending[write_reg].
- issue_valid  in  1  an instruction with a destination issues this cycle.
- issue_reg  in  ADDR_WIDTH  destination index to mark pending.
- rs_pending  out  1  combinational: pending[rs], after writeback clear.
- rt_pending  out  1  combinational: pending[rt], after writeback clear.
- dbg_addr  in  ADDR_WIDTH  debug read index.
- dbg_data  out  DATA_WIDTH  combinational contents of REG[dbg_addr]; no bypass.

Behaviour:
- Reset (rst=1, asynchronous):
  - all REG entries = 0, all pending bits = 0, A = 0, B = 0.
  - Holds while rst is high; writes and issues are ignored.
  - Deasserting mid-operation leaves the file clean; the first edge after deassertion operates normally.
- Write:
  - On posedge, if reg_write and !(ZERO_REG && write_reg==0), REG[write_reg] <= write_data.
  - Full DATA_WIDTH; no partial writes.
- Read (1-cycle latency):
  - On posedge, A <= value(rs) and B <= value(rt).
  - value(x) = 0 if ZERO_REG && x==0.
  - Otherwise value(x) = write_data if BYPASS && an effective write to x happens this cycle.
  - Otherwise value(x) = REG[x] before the edge.
  - Reading and writing the same index with BYPASS=0 gives the old value in A/B; the new value is visible from the next read.
  - rs==rt is legal; A and B are identical.
- Scoreboard (one bit per register):
  - At posedge, an effective writeback clears pending[write_reg].
  - An issue_valid sets pending[issue_reg].
  - If both hit the same index in one cycle, set wins: the newly issued producer supersedes the completing one, and the bit stays 1.
  - If ZERO_REG, index 0 is never pending; an issue to 0 is ignored.
  - Pending bits are independent of reg_write data; a writeback to a non-pending register is legal and leaves it 0.
- Hazard outputs:
  - rs_pending = pending[rs] && !(reg_write && write_reg==rs && effective write).
  - rt_pending is the same with rt.
  - A writeback in the current cycle resolves the hazard combinationally, which pairs with BYPASS for a zero-bubble resume.
  - An issue in the current cycle does not affect the outputs until the next cycle.
- dbg_data:
  - Combinational from the array.
  - Returns 0 for index 0 when ZERO_REG.
  - Does not reflect a same-cycle write until after the edge.
- No X propagation: all outputs are defined from reset onward.

Test Plan:
- Reset clear: write 0xDEADBEEF to r5, then pulse rst asynchronously between edges → A, B, and dbg_data(r5) = 0 immediately, and rs_pending = 0 for every index.
- Write/read latency: write r7 = 0x12345678 in cycle 0; set rs = 7 in cycle 1 → A = 0x12345678 after the cycle-1 edge; dbg_data(7) = 0x12345678 after the cycle-0 edge.
- Bypass: BYPASS=1, same cycle reg_write r3 = 0xA5A5A5A5 with rs = rt = 3 → A = B = 0xA5A5A5A5 after that edge. Repeat with BYPASS=0 → A = B = the old value (0), and the next read returns 0xA5A5A5A5.
- Zero register: ZERO_REG=1, write r0 = 0xFFFFFFFF and issue r0 → A(rs=0) = 0, dbg_data(0) = 0, rs_pending = 0. With ZERO_REG=0, r0 reads 0xFFFFFFFF.
- Scoreboard: issue r9 → rs_pending = 1 next cycle. Writeback r9 with rs = 9 → rs_pending = 0 in the same cycle, and A = the written value with BYPASS. Then issue r9 and writeback r9 in the same cycle → pending stays 1.
- Parametrisation: DATA_WIDTH=64, ADDR_WIDTH=3 → write r7 = 0x0123456789ABCDEF and read it back exactly; index wrap is not possible, and all 8 entries are independently writable.
